// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit seven-segment scanner.
// Lights one digit at a time for REFRESH_DIV clocks, snapshots the inputs at
// the start of every frame, decodes BCD to segments and blanks leading zeros.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bcd_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_blank,
  output logic [7:0]  seg_com,
  output logic [7:0]  seg_data
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler_reg;
  logic [2:0]    idx_reg;
  logic [31:0]   bcd_snap;
  logic [7:0]    dp_snap;
  logic          lz_snap;

  logic          tick;
  logic          new_frame;
  logic [2:0]    idx_next;
  logic [3:0]    digit_next;
  logic          dp_next;
  logic          blank_next;
  logic [6:0]    seg7_next;
  logic [7:1]    zero_from;
  logic [7:0]    blank_vec;

  assign tick      = (prescaler_reg == PRESCALE_LAST);
  assign idx_next  = idx_reg + 3'd1;          // natural 7 -> 0 wrap
  assign new_frame = (idx_reg == 3'd7);

  // zero_from[k]: snapshot digit k and every higher digit are 0
  assign zero_from[7] = (bcd_snap[31:28] == 4'd0);
  generate
    for (genvar gi = 1; gi < 7; gi++) begin : g_zero_chain
      assign zero_from[gi] = (bcd_snap[4*gi +: 4] == 4'd0) && zero_from[gi+1];
    end
  endgenerate

  // Digit 0 is never blanked, so its slot is tied low.
  assign blank_vec = {zero_from & {7{lz_snap}}, 1'b0};

  // Digit 0 of a new frame uses the live inputs being captured on this tick;
  // every other digit reads the frame snapshot so a frame never tears.
  assign digit_next = new_frame ? bcd_in[3:0] : bcd_snap[{idx_next, 2'b00} +: 4];
  assign dp_next    = new_frame ? dp_in[0]    : dp_snap[idx_next];
  assign blank_next = !new_frame && blank_vec[idx_next];

  // BCD to segments a..g; codes A..F show a dash
  always_comb begin
    seg7_next = 7'h01;
    case (digit_next)
      4'd0: seg7_next = 7'h7E;
      4'd1: seg7_next = 7'h30;
      4'd2: seg7_next = 7'h6D;
      4'd3: seg7_next = 7'h79;
      4'd4: seg7_next = 7'h33;
      4'd5: seg7_next = 7'h5B;
      4'd6: seg7_next = 7'h5F;
      4'd7: seg7_next = 7'h70;
      4'd8: seg7_next = 7'h7F;
      4'd9: seg7_next = 7'h7B;
      default: seg7_next = 7'h01;
    endcase
  end

  // Prescaler, digit index, frame snapshot and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg <= '0;
      idx_reg       <= 3'd7;
      bcd_snap      <= '0;
      dp_snap       <= '0;
      lz_snap       <= 1'b0;
      seg_com       <= 8'hFF;
      seg_data      <= 8'h00;
    end else begin
      prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
      if (tick) begin
        idx_reg  <= idx_next;
        seg_com  <= ~(8'b1 << idx_next);
        seg_data <= {(blank_next ? 7'h00 : seg7_next), dp_next};
        if (new_frame) begin
          bcd_snap <= bcd_in;
          dp_snap  <= dp_in;
          lz_snap  <= lz_blank;
        end
      end
    end
  end

endmodule
